// File: rtl/arm_pose_sequencer_if.sv
// Bundles the command, servo feedback and servo command signals between the
// navigation controller, the arm pose sequencer and the three servo channels.
//   frame_tick        : one-cycle pulse per servo PWM frame
//   start / abort     : one-cycle commands from the navigation controller
//   *_flag            : per-servo at-position feedback
//   *_desired         : per-servo position commands (20 bit)
//   busy/done/fault   : sequencer status; step is the current/last pose index
// The sequencer uses the slave modport; the controlling side uses master.
interface arm_pose_sequencer_if;
   logic        frame_tick;
   logic        start;
   logic        abort;
   logic        claw_flag;
   logic        jointhigh_flag;
   logic        jointlow_flag;
   logic [19:0] claw_desired;
   logic [19:0] jointhigh_desired;
   logic [19:0] jointlow_desired;
   logic        busy;
   logic        done;
   logic        fault;
   logic [1:0]  step;

   modport slave (
      input  frame_tick, start, abort, claw_flag, jointhigh_flag, jointlow_flag,
      output claw_desired, jointhigh_desired, jointlow_desired, busy, done, fault, step
   );

   modport master (
      output frame_tick, start, abort, claw_flag, jointhigh_flag, jointlow_flag,
      input  claw_desired, jointhigh_desired, jointlow_desired, busy, done, fault, step
   );
endinterface

// File: rtl/arm_pose_sequencer.sv
// Steps the claw, upper joint and lower joint servos through a fixed four-pose
// pick-and-place cycle. Each axis is slew limited per frame tick, a pose is
// accepted only after a run of consecutive all-at-position frames, and a
// per-pose frame budget raises a sticky fault.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (outputs return to the park pose)
//   bus_io  : command/status/servo signals, see arm_pose_sequencer_if
module arm_pose_sequencer #(
   parameter int unsigned StepMax       = 4000,
   parameter int unsigned SettleFrames  = 5,
   parameter int unsigned TimeoutFrames = 150
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   arm_pose_sequencer_if.slave   bus_io
);

   // Pose vectors packed as {claw, upper joint, lower joint}.
   typedef logic [2:0][19:0] pose_t;

   localparam pose_t Pose0 = {20'd1,      20'd31248,  20'd183400};
   localparam pose_t Pose1 = {20'd199218, 20'd31248,  20'd183400};
   localparam pose_t Pose2 = {20'd199218, 20'd191394, 20'd113274};
   localparam pose_t Pose3 = {20'd1,      20'd191394, 20'd113274};
   localparam pose_t Park  = {20'd1,      20'd113274, 20'd191394};

   localparam int unsigned SetW = $clog2(SettleFrames + 1);
   localparam int unsigned TmoW = $clog2(TimeoutFrames + 1);

   typedef enum logic [1:0] {StIdle, StMove, StSettle, StFault} state_e;

   state_e          state_q, state_d;
   pose_t           des_q, des_d;
   pose_t           tgt_q, tgt_d;
   logic [1:0]      step_q, step_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            fault_q, fault_d;
   logic            abort_q, abort_d;
   logic [SetW-1:0] settle_q, settle_d;
   logic [TmoW-1:0] tmo_q, tmo_d;

   function automatic pose_t pose_of(input logic [1:0] idx);
      pose_t p;
      unique case (idx)
         2'd0:    p = Pose0;
         2'd1:    p = Pose1;
         2'd2:    p = Pose2;
         default: p = Pose3;
      endcase
      return p;
   endfunction

   // Move one axis toward its target by at most StepMax; never overshoots.
   function automatic logic [19:0] slew(input logic [19:0] cur, input logic [19:0] tgt);
      logic [20:0] diff;
      logic [19:0] nxt;
      if (tgt >= cur) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         nxt  = (diff <= 21'(StepMax)) ? tgt : cur + 20'(StepMax);
      end else begin
         diff = {1'b0, cur} - {1'b0, tgt};
         nxt  = (diff <= 21'(StepMax)) ? tgt : cur - 20'(StepMax);
      end
      return nxt;
   endfunction

   logic at_target;
   logic flags_ok;
   logic tmo_hit;

   assign at_target = (des_q == tgt_q);
   assign flags_ok  = bus_io.claw_flag & bus_io.jointhigh_flag & bus_io.jointlow_flag;
   assign tmo_hit   = (tmo_q == TmoW'(TimeoutFrames));

   always_comb begin
      state_d  = state_q;
      des_d    = des_q;
      tgt_d    = tgt_q;
      step_d   = step_q;
      done_d   = 1'b0;
      fault_d  = fault_q;
      abort_d  = abort_q;
      settle_d = settle_q;
      tmo_d    = tmo_q;

      if (bus_io.abort) begin
         // Abort wins over start and retargets park from wherever desired is now.
         tgt_d    = Park;
         abort_d  = 1'b1;
         fault_d  = 1'b0;
         settle_d = '0;
         tmo_d    = '0;
         state_d  = StMove;
      end else begin
         unique case (state_q)
            StIdle, StFault: begin
               if (bus_io.start) begin
                  step_d   = 2'd0;
                  tgt_d    = Pose0;
                  abort_d  = 1'b0;
                  fault_d  = 1'b0;
                  settle_d = '0;
                  tmo_d    = '0;
                  state_d  = StMove;
               end
            end
            StMove: begin
               if (tmo_hit) begin
                  fault_d = 1'b1;
                  state_d = StFault;
               end else if (at_target) begin
                  settle_d = '0;
                  state_d  = StSettle;
               end else if (bus_io.frame_tick) begin
                  for (int i = 0; i < 3; i++) begin
                     des_d[i] = slew(des_q[i], tgt_q[i]);
                  end
                  tmo_d = tmo_q + 1'b1;
               end
            end
            StSettle: begin
               if (tmo_hit) begin
                  fault_d = 1'b1;
                  state_d = StFault;
               end else if (settle_q == SetW'(SettleFrames)) begin
                  if (abort_q) begin
                     abort_d = 1'b0;
                     state_d = StIdle;
                  end else if (step_q != 2'd3) begin
                     step_d   = step_q + 2'd1;
                     tgt_d    = pose_of(step_q + 2'd1);
                     settle_d = '0;
                     tmo_d    = '0;
                     state_d  = StMove;
                  end else begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end
               end else if (bus_io.frame_tick) begin
                  settle_d = flags_ok ? settle_q + 1'b1 : '0;
                  tmo_d    = tmo_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      busy_d = (state_d == StMove) || (state_d == StSettle);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         des_q    <= Park;
         tgt_q    <= Park;
         step_q   <= 2'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         abort_q  <= 1'b0;
         settle_q <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         des_q    <= des_d;
         tgt_q    <= tgt_d;
         step_q   <= step_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
         abort_q  <= abort_d;
         settle_q <= settle_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus_io.claw_desired      = des_q[2];
   assign bus_io.jointhigh_desired = des_q[1];
   assign bus_io.jointlow_desired  = des_q[0];
   assign bus_io.busy              = busy_q;
   assign bus_io.done              = done_q;
   assign bus_io.fault             = fault_q;
   assign bus_io.step              = step_q;

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Scoreboard bench for arm_pose_sequencer. Stimulus pushes the expected status
// for every busy->idle transition; a negedge monitor pops and compares, and
// also checks that no axis ever moves more than one slew step per sample.
module tb_arm_pose_sequencer;

   typedef struct {
      string       name;
      logic [1:0]  step;
      logic [19:0] claw;
      logic [19:0] hi;
      logic [19:0] lo;
      logic        done;
      logic        fault;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   arm_pose_sequencer_if bus ();

   arm_pose_sequencer dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   done_seen = 0;
   int   exp_done = 0;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input string name, input logic [1:0] step, input logic [19:0] claw,
                       input logic [19:0] hi, input logic [19:0] lo, input logic done,
                       input logic fault);
      exp_t e;
      e.name = name; e.step = step; e.claw = claw; e.hi = hi; e.lo = lo;
      e.done = done; e.fault = fault;
      sb.push_back(e);
      if (done) exp_done++;
   endtask

   function automatic int absdiff(input logic [19:0] a, input logic [19:0] b);
      return (a >= b) ? int'(a - b) : int'(b - a);
   endfunction

   // Monitor: busy falling edge is the DUT presenting a result.
   logic        busy_prev = 1'b0;
   logic        prev_valid = 1'b0;
   logic [19:0] p_claw, p_hi, p_lo;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_prev  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (bus.done) done_seen++;
         if (busy_prev && !bus.busy) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_idle: got step %0d, expected no event", bus.step);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.name, ".step"},  32'(bus.step),              32'(e.step));
               chk({e.name, ".claw"},  32'(bus.claw_desired),      32'(e.claw));
               chk({e.name, ".high"},  32'(bus.jointhigh_desired), 32'(e.hi));
               chk({e.name, ".low"},   32'(bus.jointlow_desired),  32'(e.lo));
               chk({e.name, ".done"},  32'(bus.done),              32'(e.done));
               chk({e.name, ".fault"}, 32'(bus.fault),             32'(e.fault));
            end
         end
         if (prev_valid) begin
            if (bus.claw_desired != p_claw)
               chk("slew_claw_le_4000", 32'(absdiff(bus.claw_desired, p_claw) <= 4000), 32'd1);
            if (bus.jointhigh_desired != p_hi)
               chk("slew_high_le_4000", 32'(absdiff(bus.jointhigh_desired, p_hi) <= 4000), 32'd1);
            if (bus.jointlow_desired != p_lo)
               chk("slew_low_le_4000", 32'(absdiff(bus.jointlow_desired, p_lo) <= 4000), 32'd1);
         end
         p_claw     = bus.claw_desired;
         p_hi       = bus.jointhigh_desired;
         p_lo       = bus.jointlow_desired;
         prev_valid = 1'b1;
         busy_prev  = bus.busy;
      end
   end

   task automatic tick();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse(input logic s, input logic a);
      @(negedge clk);
      bus.start = s;
      bus.abort = a;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic set_flags(input logic c, input logic h, input logic l);
      bus.claw_flag = c; bus.jointhigh_flag = h; bus.jointlow_flag = l;
   endtask

   task automatic wait_idle(input string name, input int bound);
      bit ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         if (!bus.busy) ok = 1'b1;
         else tick();
      end
      if (!bus.busy) ok = 1'b1;
      chk({name, ".idle_within_bound"}, 32'(ok), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bus.frame_tick = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_flags(1'b1, 1'b1, 1'b1);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst.claw",  32'(bus.claw_desired),      32'd1);
      chk("rst.high",  32'(bus.jointhigh_desired), 32'd113274);
      chk("rst.low",   32'(bus.jointlow_desired),  32'd191394);
      chk("rst.step",  32'(bus.step),  32'd0);
      chk("rst.busy",  32'(bus.busy),  32'd0);
      chk("rst.done",  32'(bus.done),  32'd0);
      chk("rst.fault", 32'(bus.fault), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: full sequence, flags tied high
      push("run1", 2'd3, 20'd1, 20'd191394, 20'd113274, 1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      chk("run1.busy_after_start", 32'(bus.busy), 32'd1);
      n = 0;
      while (bus.jointhigh_desired != 20'd31248 && n < 100) begin
         tick();
         n++;
      end
      chk("run1.high_slew_ticks", 32'(n), 32'd21);
      wait_idle("run1", 600);

      // 2: one-tick flag dropout during settle of pose 1
      push("run2", 2'd3, 20'd1, 20'd191394, 20'd113274, 1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      n = 0;
      while (!(bus.step == 2'd1 && bus.claw_desired == 20'd199218) && n < 200) begin
         tick();
         n++;
      end
      chk("run2.reached_pose1", 32'(bus.claw_desired), 32'd199218);
      tick();
      tick();
      set_flags(1'b0, 1'b1, 1'b1);
      tick();
      set_flags(1'b1, 1'b1, 1'b1);
      n = 0;
      while (bus.step != 2'd2 && n < 20) begin
         tick();
         n++;
      end
      chk("run2.ticks_after_dropout", 32'(n), 32'd5);
      wait_idle("run2", 600);

      // 3: lower joint never reports at-position -> timeout fault on pose 0
      set_flags(1'b1, 1'b1, 1'b0);
      push("fault", 2'd0, 20'd1, 20'd31248, 20'd183400, 1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      n = 0;
      while (!bus.fault && n < 300) begin
         tick();
         n++;
      end
      chk("fault.ticks", 32'(n), 32'd150);
      repeat (3) tick();
      chk("fault.hold_claw", 32'(bus.claw_desired),      32'd1);
      chk("fault.hold_high", 32'(bus.jointhigh_desired), 32'd31248);
      chk("fault.hold_low",  32'(bus.jointlow_desired),  32'd183400);
      chk("fault.sticky",    32'(bus.fault),             32'd1);
      set_flags(1'b1, 1'b1, 1'b1);
      push("restart", 2'd3, 20'd1, 20'd191394, 20'd113274, 1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      chk("restart.fault_cleared", 32'(bus.fault), 32'd0);
      chk("restart.step",          32'(bus.step),  32'd0);
      wait_idle("restart", 600);

      // 4: abort mid-slew of pose 2
      pulse(1'b1, 1'b0);
      n = 0;
      while (bus.step != 2'd2 && n < 300) begin
         tick();
         n++;
      end
      chk("abort.reached_step2", 32'(bus.step), 32'd2);
      repeat (10) tick();
      push("abort", 2'd2, 20'd1, 20'd113274, 20'd191394, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);
      chk("abort.busy", 32'(bus.busy), 32'd1);
      wait_idle("abort", 300);

      // 5: start+abort together parks; start while busy ignored
      push("park", 2'd2, 20'd1, 20'd113274, 20'd191394, 1'b0, 1'b0);
      pulse(1'b1, 1'b1);
      chk("park.busy", 32'(bus.busy), 32'd1);
      chk("park.step", 32'(bus.step), 32'd2);
      tick();
      pulse(1'b1, 1'b0);
      wait_idle("park", 100);

      // 6: reset asserted mid-move
      pulse(1'b1, 1'b0);
      repeat (5) tick();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid.claw",  32'(bus.claw_desired),      32'd1);
      chk("rst_mid.high",  32'(bus.jointhigh_desired), 32'd113274);
      chk("rst_mid.low",   32'(bus.jointlow_desired),  32'd191394);
      chk("rst_mid.busy",  32'(bus.busy),  32'd0);
      chk("rst_mid.fault", 32'(bus.fault), 32'd0);
      chk("rst_mid.step",  32'(bus.step),  32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("post_rst.busy", 32'(bus.busy), 32'd0);

      chk("sb_empty",    32'(sb.size()), 32'd0);
      chk("done_pulses", 32'(done_seen), 32'(exp_done));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arm_pose_sequencer.md
Name: arm_pose_sequencer

Overview:
Sequences the three arm servos (claw, upper joint, lower joint) through a fixed four-pose pick-and-place cycle, with per-axis slew limiting, settle confirmation and timeout protection. Drives the DESIRED inputs of the three Servo instances and consumes their at-position FLAGs. Takes start/abort commands from the navigation controller and returns BUSY/DONE/FAULT status.

Parameters:
POSE0  {20'd1, 20'd31248, 20'd183400}  pick approach {claw, high, low}, claw open
POSE1  {20'd199218, 20'd31248, 20'd183400}  grip: claw closed at pick position
POSE2  {20'd199218, 20'd191394, 20'd113274}  carry to drop position, claw closed
POSE3  {20'd1, 20'd191394, 20'd113274}  release: claw open at drop position
PARK  {20'd1, 20'd113274, 20'd191394}  rest pose, used at reset and on abort
STEP_MAX  20'd4000  max change per axis per FRAME_TICK
SETTLE_FRAMES  5  consecutive all-FLAG ticks required to accept a pose
TIMEOUT_FRAMES  150  max ticks per pose (MOVE+SETTLE) before fault

Ports:
CLK  in  1  system clock, 100 MHz
RST_N  in  1  asynchronous active-low reset
FRAME_TICK  in  1  one-cycle pulse per servo PWM frame (COUNT wrap)
START  in  1  one-cycle request to run POSE0..POSE3
ABORT  in  1  one-cycle request to return to PARK
CLAW_FLAG  in  1  claw servo at-position
JOINTHIGH_FLAG  in  1  upper joint at-position
JOINTLOW_FLAG  in  1  lower joint at-position
CLAW_DESIRED  out  20  claw command
JOINTHIGH_DESIRED  out  20  upper joint command
JOINTLOW_DESIRED  out  20  lower joint command
BUSY  out  1  high in MOVE/SETTLE
DONE  out  1  one-cycle pulse after POSE3 is accepted
FAULT  out  1  sticky timeout indication
STEP  out  2  index of current/last pose

Behaviour:
- Reset (async on RST_N low): state=IDLE, DESIRED outputs = PARK, target = PARK, STEP=0, BUSY=0, DONE=0, FAULT=0, all counters 0, abort_mode=0.
- States: IDLE, MOVE, SETTLE, FAULT. All outputs registered.
- IDLE: START -> STEP=0, target=POSE0, MOVE. ABORT -> target=PARK, abort_mode=1, MOVE.
- MOVE: on each FRAME_TICK, per axis: if |target-desired| <= STEP_MAX then desired=target, else desired moves toward target by exactly STEP_MAX. Difference computed in 21 bits; no wrap or overshoot. In the first cycle where all three desired==target -> SETTLE, settle_cnt=0.
- SETTLE: on each FRAME_TICK, if all three FLAGs are high, settle_cnt++; otherwise settle_cnt=0. When settle_cnt reaches SETTLE_FRAMES:
  - abort_mode: -> IDLE, abort_mode=0, no DONE.
  - STEP<3: STEP++, target=next pose, MOVE.
  - STEP==3: DONE pulses one cycle, -> IDLE.
- Timeout: tmo_cnt clears on every pose entry, and increments on FRAME_TICK in MOVE/SETTLE. When tmo_cnt==TIMEOUT_FRAMES -> FAULT: FAULT=1, desired held, BUSY=0.
- FAULT: START clears FAULT and restarts at POSE0. ABORT clears FAULT and parks. Otherwise FAULT holds indefinitely.
- BUSY=1 exactly in MOVE and SETTLE.
- START while BUSY is ignored.
- ABORT in any state, including mid-slew, retargets PARK from the current desired values. No jump; slew continues.
- START and ABORT asserted in the same cycle: ABORT wins.
- A FRAME_TICK in the same cycle as a state transition is consumed by that transition and is not counted in the new state.
- STEP holds its last value in IDLE and FAULT.

Test Plan:
- Reset, then START with FLAGs tied high -> desired slews PARK->POSE0 in 4000-count steps. Upper joint 113274->31248 takes 21 ticks. STEP runs 0..3, DONE pulses once, final desired=POSE3, BUSY low.
- FLAGs held high except one 1-tick low dropout during SETTLE of POSE1 -> settle_cnt restarts; pose accepted 5 ticks after the dropout.
- JOINTLOW_FLAG held low -> FAULT=1 after 150 ticks of POSE0, desired frozen. Then START -> FAULT cleared, sequence restarts at STEP=0.
- ABORT mid-slew in POSE2 -> desired reverses toward PARK with no step exceeding 4000. Returns to IDLE with no DONE pulse and STEP=2.
- START and ABORT in the same cycle from IDLE -> park behaviour only. START during BUSY -> no effect.
- RST_N asserted mid-MOVE -> outputs immediately return to PARK values, state IDLE, FAULT=0.
